// File: rtl/serdes_pkg.sv
// Shared definitions for the split-packet serdes link: header field positions
// and the receive-side depacketizer state encoding.
package serdes_pkg;

  localparam int HDR_VALID_BIT = 0;
  localparam int HDR_ID_BIT    = 1;
  localparam int HDR_NPKTS_LSB = 2;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    SKIP
  } depkt_state_t;

endpackage

// File: rtl/depkt_payload_fifo.sv
// Single-clock first-word-fall-through payload queue with occupancy outputs.
// Pointers carry an extra wrap bit so full and empty are distinguishable.
module depkt_payload_fifo #(
  parameter int WIDTH     = 128,
  parameter int DEPTH     = 4,
  parameter int DEPTH_LOG = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push,
  input  logic [WIDTH-1:0]     push_data,
  input  logic                 pop,
  output logic [WIDTH-1:0]     head,
  output logic [DEPTH_LOG:0]   count,
  output logic [DEPTH_LOG:0]   free,
  output logic                 push_accept
);

  localparam logic [DEPTH_LOG:0] DEPTH_C = (DEPTH_LOG + 1)'(DEPTH);

  logic [WIDTH-1:0]   mem [DEPTH];
  logic [DEPTH_LOG:0] wr_ptr;
  logic [DEPTH_LOG:0] rd_ptr;
  logic               full;
  logic               pop_ok;

  assign count  = wr_ptr - rd_ptr;
  assign free   = DEPTH_C - count;
  assign full   = (count == DEPTH_C);
  assign pop_ok = pop && (count != '0);
  // A pop in the same cycle frees the slot the write lands in.
  assign push_accept = push && (!full || pop_ok);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      if (push_accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)      rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is not reset; the pointers alone decide which entries are meaningful.
  always_ff @(posedge clk) begin
    if (push_accept) mem[wr_ptr[DEPTH_LOG-1:0]] <= push_data;
  end

  assign head = mem[rd_ptr[DEPTH_LOG-1:0]];

endmodule

// File: rtl/depacketizer_split.sv
// Receive side of the split-packet serdes link: rebuilds own-ID bursts into
// payloads and queues them for the consumer. Optional DEPACKETIZER_ERR_CHECK_EN adds err_o.
module depacketizer_split
  import serdes_pkg::*;
#(
  parameter int PAYLOAD_WIDTH = 128,
  parameter int PACKET_WIDTH  = 16,
  parameter int ID            = 0,
  parameter int DEPTH         = 4,
  parameter int DEPTH_LOG     = 2,
  parameter int N_PKTS_BITS   = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [PACKET_WIDTH-1:0]  packet_i,
  output logic                     rx_ready_o,
  output logic                     payload_req_o,
  output logic [PAYLOAD_WIDTH-1:0] payload_o,
  input  logic                     payload_grant_i
`ifdef DEPACKETIZER_ERR_CHECK_EN
  ,
  output logic                     err_o
`endif
);

  localparam int N_PKTS = PAYLOAD_WIDTH / PACKET_WIDTH;
  localparam int H      = PACKET_WIDTH / 2;
  localparam int HALF   = PAYLOAD_WIDTH / 2;
  localparam int CNT_W  = (N_PKTS_BITS > $clog2(N_PKTS + 1)) ? N_PKTS_BITS : $clog2(N_PKTS + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(N_PKTS);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  depkt_state_t       state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [HALF-1:0]    asm_lo, asm_hi;
  logic [HALF-1:0]    asm_lo_nxt, asm_hi_nxt;
  logic               shift_en;
  logic               push;
  logic               pop;
  logic               push_accept;
  logic               rx_ready_nxt;
  logic               hdr_own;
  logic [CNT_W-1:0]   hdr_len;
  logic [DEPTH_LOG:0] count, free, free_nxt;
`ifdef DEPACKETIZER_ERR_CHECK_EN
  logic               hdr_err;
`endif

  assign hdr_own = (packet_i[HDR_ID_BIT] == 1'(ID));
  assign hdr_len = CNT_W'(packet_i[HDR_NPKTS_LSB +: N_PKTS_BITS]);

  // Halves shift in from the top, so after N_PKTS packets packet 0 sits at the LSB.
  assign asm_lo_nxt = {packet_i[H-1:0], asm_lo[HALF-1:H]};
  assign asm_hi_nxt = {packet_i[PACKET_WIDTH-1:H], asm_hi[HALF-1:H]};

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    state_nxt = state;
    cnt_nxt   = cnt;
    shift_en  = 1'b0;
    push      = 1'b0;
`ifdef DEPACKETIZER_ERR_CHECK_EN
    hdr_err   = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (packet_i[HDR_VALID_BIT]) begin
          if (hdr_own) begin
`ifdef DEPACKETIZER_ERR_CHECK_EN
            if (hdr_len != CNT_FULL) begin
              hdr_err = 1'b1;
              if (hdr_len != '0) begin
                state_nxt = SKIP;
                cnt_nxt   = hdr_len;
              end
            end else begin
              state_nxt = COLLECT;
              cnt_nxt   = CNT_FULL;
            end
`else
            state_nxt = COLLECT;
            cnt_nxt   = CNT_FULL;
`endif
          end else if (hdr_len != '0) begin
            state_nxt = SKIP;
            cnt_nxt   = hdr_len;
          end
        end
      end
      COLLECT: begin
        shift_en = 1'b1;
        cnt_nxt  = cnt - CNT_ONE;
        if (cnt == CNT_ONE) begin
          push      = 1'b1;
          state_nxt = IDLE;
        end
      end
      SKIP: begin
        cnt_nxt = cnt - CNT_ONE;
        if (cnt == CNT_ONE) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  depkt_payload_fifo #(
    .WIDTH     (PAYLOAD_WIDTH),
    .DEPTH     (DEPTH),
    .DEPTH_LOG (DEPTH_LOG)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push        (push),
    .push_data   ({asm_hi_nxt, asm_lo_nxt}),
    .pop         (pop),
    .head        (payload_o),
    .count       (count),
    .free        (free),
    .push_accept (push_accept)
  );

  assign payload_req_o = (count != '0);
  assign pop           = payload_req_o && payload_grant_i;

  // An assembly in flight has a queue slot reserved for it.
  assign free_nxt     = free + (DEPTH_LOG + 1)'(pop) - (DEPTH_LOG + 1)'(push_accept);
  assign rx_ready_nxt = free_nxt > (DEPTH_LOG + 1)'(state_nxt == COLLECT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      asm_lo     <= '0;
      asm_hi     <= '0;
      rx_ready_o <= 1'b1;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      rx_ready_o <= rx_ready_nxt;
      if (shift_en) begin
        asm_lo <= asm_lo_nxt;
        asm_hi <= asm_hi_nxt;
      end
    end
  end

`ifdef DEPACKETIZER_ERR_CHECK_EN
  logic full;
  assign full = (free == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_o <= 1'b0;
    end else if (hdr_err || (push && full && !pop)) begin
      err_o <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_depacketizer_split.sv
// Randomized scoreboard bench for depacketizer_split; a stream-level reference
// model tracks the expected queue contents, rx_ready and (optionally) err_o.
module tb_depacketizer_split;

  localparam int PW    = 128;
  localparam int KW    = 16;
  localparam int N     = 8;
  localparam int H     = 8;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [KW-1:0] packet_i = '0;
  logic          grant = 1'b0;
  logic          rx_ready_o;
  logic          payload_req_o;
  logic [PW-1:0] payload_o;
`ifdef DEPACKETIZER_ERR_CHECK_EN
  logic          err_o;
`endif

  depacketizer_split dut (
    .clk             (clk),
    .reset           (reset),
    .packet_i        (packet_i),
    .rx_ready_o      (rx_ready_o),
    .payload_req_o   (payload_req_o),
    .payload_o       (payload_o),
    .payload_grant_i (grant)
`ifdef DEPACKETIZER_ERR_CHECK_EN
    ,
    .err_o           (err_o)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(string name, logic [PW-1:0] act, logic [PW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: interprets the packet stream as bursts and keeps the
  // expected queue contents as a plain SV queue.
  logic [PW-1:0] mq[$];
  int            rem = 0;
  bit            own = 0;
  int            k = 0;
  logic [PW-1:0] acc = '0;
  bit            m_err = 0;

  initial forever begin
    int sz;
    bit do_pop;
    bit done;
    int n;
    @(posedge clk or posedge reset);
    if (reset) begin
      mq.delete();
      rem   = 0;
      own   = 0;
      m_err = 0;
    end else begin
      sz     = mq.size();
      do_pop = (sz > 0) && grant;
      done   = 0;
      if (rem == 0) begin
        if (packet_i[0]) begin
          n = int'(packet_i[5:2]);
          k = 0;
          if (packet_i[1] == 1'b0) begin
`ifdef DEPACKETIZER_ERR_CHECK_EN
            if (n != N) begin
              m_err = 1;
              rem   = n;
              own   = 0;
            end else begin
              rem = N;
              own = 1;
            end
`else
            rem = N;
            own = 1;
`endif
          end else begin
            rem = n;
            own = 0;
          end
        end
      end else begin
        if (own) begin
          acc[k*H +: H]        = packet_i[H-1:0];
          acc[PW/2 + k*H +: H] = packet_i[KW-1:H];
          k++;
        end
        rem--;
        if (rem == 0 && own) done = 1;
      end
      if (do_pop) void'(mq.pop_front());
      if (done) begin
        if (sz < DEPTH || do_pop) mq.push_back(acc);
        else m_err = 1;
      end
    end
  end

  // Monitor: compares DUT outputs against the model away from the active edge.
  int n_pops = 0;
  initial forever begin
    int exp_rx;
    @(negedge clk);
    exp_rx = ((DEPTH - mq.size()) - ((rem > 0 && own) ? 1 : 0)) >= 1 ? 1 : 0;
    check("payload_req", PW'(payload_req_o), PW'(mq.size() > 0));
    if (mq.size() > 0) check("payload", payload_o, mq[0]);
    check("rx_ready", PW'(rx_ready_o), PW'(exp_rx));
`ifdef DEPACKETIZER_ERR_CHECK_EN
    check("err", PW'(err_o), PW'(m_err));
`endif
    if (payload_req_o && grant) n_pops++;
  end

  task automatic drive(logic [KW-1:0] p, logic g);
    packet_i = p;
    grant    = g;
    @(posedge clk);
    #1;
  endtask

  // Own-ID burst; g_last applies to the final data packet only.
  task automatic burst(logic [PW-1:0] pl, logic g, logic g_last);
    drive(16'h0021, g);
    for (int i = 0; i < N; i++)
      drive({pl[PW/2 + i*H +: H], pl[i*H +: H]}, (i == N-1) ? g_last : g);
  endtask

  function automatic logic [PW-1:0] rnd_payload();
    logic [PW-1:0] r;
    for (int i = 0; i < PW/32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  logic [PW-1:0] pl;
  logic [PW-1:0] first_pl;
  logic [KW-1:0] p;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("reset_req", PW'(payload_req_o), PW'(0));
    check("reset_rx_ready", PW'(rx_ready_o), PW'(1));
    reset = 1'b0;
    drive(16'h0000, 1'b0);

    // Basic burst with the documented data pattern.
    for (int i = 0; i < N; i++) begin
      pl[i*H +: H]        = H'(i);
      pl[PW/2 + i*H +: H] = H'(8'h80 + i);
    end
    burst(pl, 1'b0, 1'b0);
    check("basic_req", PW'(payload_req_o), PW'(1));
    check("basic_payload", payload_o, 128'h8786858483828180_0706050403020100);
    drive(16'h0000, 1'b1);
    drive(16'h0000, 1'b0);

    // Foreign-ID burst (one data packet has bit0 set) then an own header at once.
    drive(16'h0023, 1'b0);
    for (int i = 0; i < N; i++) drive((i == 3) ? 16'hA5A5 : 16'h5A5A, 1'b0);
    check("foreign_no_push", PW'(payload_req_o), PW'(0));
    pl = rnd_payload();
    burst(pl, 1'b0, 1'b0);
    check("after_foreign_payload", payload_o, pl);
    drive(16'h0000, 1'b1);

    // Back-to-back bursts, no grant: fill the queue and overflow it.
    first_pl = rnd_payload();
    burst(first_pl, 1'b0, 1'b0);
    for (int b = 1; b < 5; b++) burst(rnd_payload(), 1'b0, 1'b0);
    check("full_rx_ready", PW'(rx_ready_o), PW'(0));
    check("full_head_kept", payload_o, first_pl);

    // Burst ending with a grant while full: simultaneous push and pop.
    burst(rnd_payload(), 1'b0, 1'b1);
    check("pushpop_head", PW'(payload_req_o), PW'(1));
    for (int i = 0; i < 3; i++) drive(16'h0000, 1'b1);
    // Keep granting while a new burst streams in, so pointers wrap.
    burst(rnd_payload(), 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) drive(16'h0000, 1'b1);
    check("drained", PW'(payload_req_o), PW'(0));

    // Randomized traffic mix.
    for (int b = 0; b < 40; b++) begin
      if ($urandom_range(0, 3) != 0) begin
        pl = rnd_payload();
        drive(16'h0021, 1'($urandom_range(0, 2) == 0));
        for (int i = 0; i < N; i++)
          drive({pl[PW/2 + i*H +: H], pl[i*H +: H]}, 1'($urandom_range(0, 2) == 0));
      end else begin
        int nf;
        nf = $urandom_range(0, 15);
        drive({10'b0, 4'(nf), 2'b11}, 1'($urandom_range(0, 2) == 0));
        for (int i = 0; i < nf; i++) drive(16'($urandom), 1'($urandom_range(0, 2) == 0));
      end
      repeat ($urandom_range(0, 2)) drive(16'h0000, 1'($urandom_range(0, 1) == 1));
    end
    repeat (6) drive(16'h0000, 1'b1);
    check("random_drained", PW'(payload_req_o), PW'(0));

    // Reset in the middle of a burst, with an entry already queued.
    burst(rnd_payload(), 1'b0, 1'b0);
    drive(16'h0021, 1'b0);
    for (int i = 0; i < 4; i++) drive(16'($urandom), 1'b0);
    reset    = 1'b1;
    packet_i = '0;
    #2;
    check("midreset_req", PW'(payload_req_o), PW'(0));
    check("midreset_rx_ready", PW'(rx_ready_o), PW'(1));
    reset = 1'b0;
    @(posedge clk);
    #1;
    pl = rnd_payload();
    burst(pl, 1'b0, 1'b0);
    check("post_reset_payload", payload_o, pl);
    drive(16'h0000, 1'b1);
    drive(16'h0000, 1'b0);

`ifdef DEPACKETIZER_ERR_CHECK_EN
    // Own-ID header with a wrong length: flagged and its packets skipped.
    drive(16'h0011, 1'b0);
    for (int i = 0; i < 4; i++) begin
      p = 16'($urandom);
      drive(p, 1'b0);
    end
    check("err_set", PW'(err_o), PW'(1));
    check("err_no_push", PW'(payload_req_o), PW'(0));
    repeat (3) drive(16'h0000, 1'b0);
    check("err_sticky", PW'(err_o), PW'(1));
`endif

    check("pops_seen", PW'(n_pops > 0), PW'(1));
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
